// File: rtl/uart_rx_req.sv
// uart_rx_req: 8N1 serial receiver (LSB first) feeding a downstream command
// port over a 4-phase cmd_req/cmd_ack handshake. A single holding register
// lets the next byte be received while the current one is being acknowledged.
// Overrun and framing errors are reported as single-cycle pulses.
module uart_rx_req #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       cmd_req,
    output logic [7:0] cmd_data,
    input  logic       cmd_ack,
    output logic       ovr_err,
    output logic       frm_err
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rxState_t;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_REQ,
        HS_WAIT_LOW
    } hsState_t;

    logic             rxMeta_q;
    logic             rxSync_q;
    rxState_t         rxState_q;
    logic             armed_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       bitIdx_q;
    logic [7:0]       shift_q;
    hsState_t         hsState_q;
    logic             cmdReq_q;
    logic [7:0]       cmdData_q;
    logic             ovrErr_q;
    logic             frmErr_q;

    logic             stopSample;
    logic             byteDone;
    logic             holdFree;

    assign cnt_d      = cnt_q + 1'b1;
    assign stopSample = (rxState_q == STOP) && (cnt_q == BIT_LAST);
    assign byteDone   = stopSample && rxSync_q;
    // The holding register may be reused in the very cycle the consumer drops ack.
    assign holdFree   = (hsState_q == HS_IDLE) ||
                        ((hsState_q == HS_WAIT_LOW) && !cmd_ack);

    assign cmd_req  = cmdReq_q;
    assign cmd_data = cmdData_q;
    assign ovr_err  = ovrErr_q;
    assign frm_err  = frmErr_q;

    // Two-flop synchronizer for the asynchronous rx line; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // Receive FSM: start-bit qualification at mid-bit, eight data bits, stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxState_q <= IDLE;
            armed_q   <= 1'b0;
            cnt_q     <= '0;
            bitIdx_q  <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            case (rxState_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rxSync_q) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        rxState_q <= START;
                        armed_q   <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!rxSync_q) begin
                            rxState_q <= DATA;
                            bitIdx_q  <= 3'd0;
                        end else begin
                            rxState_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q             <= '0;
                        shift_q[bitIdx_q] <= rxSync_q;
                        bitIdx_q          <= bitIdx_q + 3'd1;
                        if (bitIdx_q == 3'd7) begin
                            rxState_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        rxState_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    rxState_q <= IDLE;
                    cnt_q     <= '0;
                end
            endcase
        end
    end

    // Holding register, 4-phase handshake FSM and registered error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsState_q <= HS_IDLE;
            cmdReq_q  <= 1'b0;
            cmdData_q <= 8'h00;
            ovrErr_q  <= 1'b0;
            frmErr_q  <= 1'b0;
        end else begin
            ovrErr_q <= byteDone && !holdFree;
            frmErr_q <= stopSample && !rxSync_q;
            if (byteDone && holdFree) begin
                cmdData_q <= shift_q;
                cmdReq_q  <= 1'b1;
                hsState_q <= HS_REQ;
            end else begin
                case (hsState_q)
                    HS_IDLE: begin
                        cmdReq_q <= 1'b0;
                    end
                    HS_REQ: begin
                        if (cmd_ack) begin
                            cmdReq_q  <= 1'b0;
                            hsState_q <= HS_WAIT_LOW;
                        end
                    end
                    HS_WAIT_LOW: begin
                        if (!cmd_ack) begin
                            hsState_q <= HS_IDLE;
                        end
                    end
                    default: begin
                        cmdReq_q  <= 1'b0;
                        hsState_q <= HS_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_req.sv
// tb_uart_rx_req: scenario-driven bench for uart_rx_req with a short bit
// period. Bytes are serialized by the bench, delivered bytes and error
// pulses are collected by monitors and compared against bench expectations.
module tb_uart_rx_req;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       cmd_ack;
    logic       cmd_req;
    logic [7:0] cmd_data;
    logic       ovr_err;
    logic       frm_err;

    int         checks = 0;
    int         failures = 0;
    int         ovrCount = 0;
    int         frmCount = 0;
    logic [7:0] gotBytes[$];
    int         ackMode = 0;
    logic       reqDly = 1'b0;
    logic       prevReq = 1'b0;

    uart_rx_req #(
        .CLKS_PER_BIT(CPB),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .cmd_req(cmd_req),
        .cmd_data(cmd_data),
        .cmd_ack(cmd_ack),
        .ovr_err(ovr_err),
        .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    // Monitor: count error-pulse cycles and record each byte offered on cmd_req.
    initial begin
        forever begin
            @(negedge clk);
            if (ovr_err === 1'b1) ovrCount++;
            if (frm_err === 1'b1) frmCount++;
            if (cmd_req === 1'b1 && prevReq !== 1'b1) gotBytes.push_back(cmd_data);
            prevReq = cmd_req;
        end
    end

    // Consumer model: mode 1 echoes cmd_req, mode 2 echoes it one cycle late,
    // mode 0 leaves cmd_ack to the running scenario.
    initial begin
        forever begin
            @(negedge clk);
            if (ackMode == 1) cmd_ack = cmd_req;
            else if (ackMode == 2) cmd_ack = reqDly;
            reqDly = cmd_req;
        end
    end

    // Serialize one 8N1 frame; called and returns on a negedge.
    task automatic sendByte(input logic [7:0] data, input logic stopBit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stopBit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idleLine(input int cycles);
        rx = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx = 1'b1;
        cmd_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_req got=%b exp=0", cmd_req);
        end
        checks++;
        if (cmd_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_data got=%h exp=00", cmd_data);
        end
        checks++;
        if (ovr_err !== 1'b0 || frm_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_err got=%b%b exp=00", ovr_err, frm_err);
        end
        rst = 1'b0;
        idleLine(4 * CPB);
        checks++;
        if (cmd_req !== 1'b0 || gotBytes.size() != 0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset req=%b bytes=%0d exp 0/0", cmd_req, gotBytes.size());
        end
    endtask

    task automatic test_single_byte();
        int riseCyc;
        int ovr0;
        int frm0;
        // Start edge, 2-flop sync, 1 detect cycle, half a bit, then 8 data
        // bits plus the stop bit; cmd_req is visible one cycle later.
        int expLat;
        expLat = 2 + 1 + CPB / 2 + 9 * CPB;
        riseCyc = -1;
        ovr0 = ovrCount;
        frm0 = frmCount;
        ackMode = 1;
        fork
            sendByte(8'h8F, 1'b1);
            begin
                for (int c = 1; c <= 400; c++) begin
                    @(negedge clk);
                    if (cmd_req === 1'b1 && riseCyc < 0) begin
                        riseCyc = c;
                        checks++;
                        if (cmd_data !== 8'h8F) begin
                            failures++;
                            $display("[TB] FAIL single_data got=%h exp=8f", cmd_data);
                        end
                        @(negedge clk);
                        checks++;
                        if (cmd_req !== 1'b0) begin
                            failures++;
                            $display("[TB] FAIL single_req_fall got=%b exp=0", cmd_req);
                        end
                        break;
                    end
                end
            end
        join
        idleLine(2 * CPB);
        checks++;
        if (riseCyc != expLat) begin
            failures++;
            $display("[TB] FAIL single_latency got=%0d exp=%0d", riseCyc, expLat);
        end
        checks++;
        if (ovrCount != ovr0 || frmCount != frm0) begin
            failures++;
            $display("[TB] FAIL single_no_err ovr=%0d frm=%0d exp 0/0", ovrCount - ovr0, frmCount - frm0);
        end
    endtask

    task automatic runStream(input string name, input logic [7:0] bytes[$], input bit gaps);
        int base;
        int ovr0;
        base = gotBytes.size();
        ovr0 = ovrCount;
        ackMode = 2;
        foreach (bytes[i]) begin
            sendByte(bytes[i], 1'b1);
            if (gaps) idleLine($urandom_range(0, 20));
        end
        idleLine(3 * CPB);
        checks++;
        if (gotBytes.size() - base != bytes.size()) begin
            failures++;
            $display("[TB] FAIL %s_count got=%0d exp=%0d", name, gotBytes.size() - base, bytes.size());
        end
        foreach (bytes[i]) begin
            if (base + i < gotBytes.size()) begin
                checks++;
                if (gotBytes[base + i] !== bytes[i]) begin
                    failures++;
                    $display("[TB] FAIL %s_byte%0d got=%h exp=%h", name, i, gotBytes[base + i], bytes[i]);
                end
            end
        end
        checks++;
        if (ovrCount != ovr0) begin
            failures++;
            $display("[TB] FAIL %s_no_ovr got=%0d exp=0", name, ovrCount - ovr0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pkt[$];
        pkt = '{8'h8F, 8'hC7, 8'h00, 8'h01, 8'h0A, 8'hBC, 8'hDE, 8'hF1, 8'hC7, 8'h3D};
        runStream("stream", pkt, 1'b0);
    endtask

    task automatic test_random_stream();
        logic [7:0] pkt[$];
        for (int i = 0; i < 8; i++) pkt.push_back(8'($urandom_range(0, 255)));
        runStream("random", pkt, 1'b1);
    endtask

    task automatic test_overrun();
        int base;
        int ovr0;
        base = gotBytes.size();
        ovr0 = ovrCount;
        ackMode = 0;
        cmd_ack = 1'b0;
        sendByte(8'h12, 1'b1);
        sendByte(8'h34, 1'b1);
        idleLine(2 * CPB);
        checks++;
        if (cmd_req !== 1'b1 || cmd_data !== 8'h12) begin
            failures++;
            $display("[TB] FAIL ovr_hold req=%b data=%h exp 1/12", cmd_req, cmd_data);
        end
        checks++;
        if (ovrCount - ovr0 != 1) begin
            failures++;
            $display("[TB] FAIL ovr_pulse got=%0d exp=1", ovrCount - ovr0);
        end
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        checks++;
        if (cmd_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovr_ack_fall got=%b exp=0", cmd_req);
        end
        idleLine(4 * CPB);
        checks++;
        if (cmd_req !== 1'b0 || gotBytes.size() - base != 1) begin
            failures++;
            $display("[TB] FAIL ovr_no_more req=%b bytes=%0d exp 0/1", cmd_req, gotBytes.size() - base);
        end
    endtask

    task automatic test_framing_break();
        int base;
        int frm0;
        base = gotBytes.size();
        frm0 = frmCount;
        ackMode = 1;
        sendByte(8'h55, 1'b0);
        rx = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        checks++;
        if (frmCount - frm0 != 1) begin
            failures++;
            $display("[TB] FAIL frm_pulse got=%0d exp=1", frmCount - frm0);
        end
        checks++;
        if (gotBytes.size() != base) begin
            failures++;
            $display("[TB] FAIL frm_no_byte got=%0d exp=0", gotBytes.size() - base);
        end
        idleLine(2 * CPB);
        sendByte(8'hA5, 1'b1);
        idleLine(2 * CPB);
        checks++;
        if (frmCount - frm0 != 1) begin
            failures++;
            $display("[TB] FAIL break_frm got=%0d exp=1", frmCount - frm0);
        end
        checks++;
        if (gotBytes.size() - base != 1 || cmd_data !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL break_a5 bytes=%0d data=%h exp 1/a5", gotBytes.size() - base, cmd_data);
        end
    endtask

    task automatic test_glitch();
        int base;
        int ovr0;
        int frm0;
        base = gotBytes.size();
        ovr0 = ovrCount;
        frm0 = frmCount;
        ackMode = 1;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idleLine(3 * CPB);
        checks++;
        if (gotBytes.size() != base || ovrCount != ovr0 || frmCount != frm0) begin
            failures++;
            $display("[TB] FAIL glitch_quiet bytes=%0d ovr=%0d frm=%0d exp 0/0/0",
                     gotBytes.size() - base, ovrCount - ovr0, frmCount - frm0);
        end
        sendByte(8'h3C, 1'b1);
        idleLine(2 * CPB);
        checks++;
        if (gotBytes.size() - base != 1 || cmd_data !== 8'h3C) begin
            failures++;
            $display("[TB] FAIL glitch_next bytes=%0d data=%h exp 1/3c", gotBytes.size() - base, cmd_data);
        end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] partial;
        int base;
        int ovr0;
        int frm0;
        partial = 8'hC7;
        base = gotBytes.size();
        ovr0 = ovrCount;
        frm0 = frmCount;
        ackMode = 1;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = partial[i];
            repeat (CPB) @(negedge clk);
        end
        rx = partial[3];
        repeat (CPB / 2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (cmd_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL midrst_data got=%h exp=00", cmd_data);
        end
        checks++;
        if (cmd_req !== 1'b0 || ovr_err !== 1'b0 || frm_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_flags got=%b%b%b exp=000", cmd_req, ovr_err, frm_err);
        end
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idleLine(3 * CPB);
        sendByte(8'hBC, 1'b1);
        idleLine(2 * CPB);
        checks++;
        if (gotBytes.size() - base != 1 || cmd_data !== 8'hBC) begin
            failures++;
            $display("[TB] FAIL midrst_bc bytes=%0d data=%h exp 1/bc", gotBytes.size() - base, cmd_data);
        end
        checks++;
        if (ovrCount != ovr0 || frmCount != frm0) begin
            failures++;
            $display("[TB] FAIL midrst_no_err ovr=%0d frm=%0d exp 0/0", ovrCount - ovr0, frmCount - frm0);
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        rst = 1'b1;
        rx = 1'b1;
        cmd_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_framing_break();
        test_glitch();
        test_reset_mid_byte();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
